adc_pipe_seq_ctrl: RTL and testbench
====================================

// Module: adc_pipe_seq_ctrl
// PURPOSE
//  Conversion sequencer for the 3-stage 1.5-bit pipelined ADC, driven from one master clock.
//  Generates the non-overlapping sampling phases phi1/phi2 for the MDAC stages and the encoder.
//  Runs burst or continuous conversions and holds the encoder in reset while idle.
//  Flushes the pipeline after the last sample and emits aligned 3-bit codes with a valid strobe.
// PARAMETERS
//  PH_CYC   8   clk cycles each phase (phi1, phi2) is high
//  GAP_CYC  1   clk cycles of non-overlap dead time before each phase; >=1
//  LATENCY  2   conversion periods from a phi1 sample until its code is valid on d_i; >=1
//  NS_W     8   width of the sample-count request
// PORTS
//  clk_i      in   1     master clock; all logic on its rising edge
//  reset_i    in   1     asynchronous, active-high reset
//  start_i    in   1     1-cycle start request; sampled only in IDLE
//  stop_i     in   1     request to end a run; sampled only in RUN
//  nsamp_i    in   NS_W  samples per burst, latched on accepted start; 0 = continuous
//  d_i        in   3     code from the adc_pipe_encoder_TOP output
//  phi1_o     out  1     sampling phase 1 (stage-1 S/H, stage-3 comparator)
//  phi2_o     out  1     sampling phase 2 (stage-2 S/H)
//  enc_rst_o  out  1     encoder reset; high in IDLE
//  busy_o     out  1     high in RUN or DRAIN
//  valid_o    out  1     1-cycle strobe; data_o holds a real sample code
//  data_o     out  3     captured code; holds its value between strobes
// BEHAVIOUR
//  Reset: all outputs registered; phi1_o=phi2_o=0, enc_rst_o=1, busy_o=0, valid_o=0, data_o=0.
//    Counters and tag register clear; state goes to IDLE. Reset mid-run aborts at once, with no flush and no valid.
//  Period P = 2*(GAP_CYC+PH_CYC) clks (18 by default). Phase counter pc counts 0..P-1 and wraps.
//    Phase layout:
//      pc in [0,GAP)                   both phases low
//      pc in [GAP,GAP+PH)              phi1_o=1
//      pc in [GAP+PH,2GAP+PH)          both phases low
//      pc in [2GAP+PH,P)               phi2_o=1
//    phi1_o and phi2_o are never high together, and are glitch-free (decoded, then registered).
//  States:
//    IDLE
//      pc held at 0; phases low; enc_rst_o=1.
//      On start_i: latch nsamp_i, clear sample count, go to RUN. enc_rst_o=0 from the next clk.
//      pc starts at 0 on that clk.
//    RUN
//      Each period is a real sample period; sample count +1 at pc=P-1.
//      Leave for DRAIN at pc=P-1 when either:
//        nsamp!=0 and the count reaches nsamp, or
//        stop_i was seen anywhere in this period (sticky flag).
//      stop_i together with the final burst sample gives the same result.
//    DRAIN
//      Phases keep running so the pipeline empties. These periods are tagged non-real.
//      Go to IDLE at pc=P-1 once the tag register is all zero after its shift.
//      phi2 of the last period completes before IDLE.
//  Tag shift register tag[LATENCY-1:0] advances at pc=P-1:
//    tag <= {tag[LATENCY-2:0], real_this_period}. For LATENCY=1 it is a single bit.
//    If the pre-shift tag[LATENCY-1]=1: valid_o=1 and data_o<=d_i on that same edge.
//    So the sample from period k is emitted at the end of period k+LATENCY.
//    Exactly one valid_o per real sample; never one for a DRAIN period.
//  Accepted starts: start_i and stop_i are ignored outside their state.
//    A start in DRAIN is dropped; there is no queueing.
//  Continuous mode (nsamp=0) runs until stop_i. The sample counter saturates and does not wrap.
//  busy_o=1 from the clk after an accepted start until the IDLE entry clk.
// TESTING
//  T1 reset: assert reset_i mid-RUN -> next sample: phis 0, enc_rst_o=1, busy_o=0, no valid_o.
//  T2 phases: default params, start, nsamp=4 -> each phase 8 clks high, 1-clk gaps, P=18, no overlap.
//  T3 burst: nsamp=4, d_i driven per period with 3'd0..3'd7 -> exactly 4 valid_o.
//     The first is at the end of period 2 with data_o equal to the d_i of that cycle.
//     busy_o drops after 6 periods.
//  T4 continuous: nsamp=0, stop_i in period 9 -> 10 valids, 2 drain periods, then IDLE.
//     Stop at pc=0 vs pc=17 of period 9 gives the same result.
//  T5 ignored requests: start_i during RUN/DRAIN and stop_i in IDLE -> no state, count or output change.
//  T6 edge case: nsamp=1 with stop_i in the same period -> 1 valid, then IDLE after LATENCY drain periods.
//     LATENCY=1 build repeats T3 with the first valid at the end of period 1.

Source files
------------

// File: rtl/adc_pipe_seq_ctrl.sv
// Conversion sequencer for a 3-stage 1.5-bit pipelined ADC: non-overlapping phi1/phi2,
// burst/continuous runs, pipeline flush, and latency-aligned code capture with a valid strobe.
module adc_pipe_seq_ctrl #(
    parameter int unsigned PH_CYC  = 8,
    parameter int unsigned GAP_CYC = 1,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned NS_W    = 8
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            stop_i,
    input  logic [NS_W-1:0] nsamp_i,
    input  logic [2:0]      d_i,
    output logic            phi1_o,
    output logic            phi2_o,
    output logic            enc_rst_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [2:0]      data_o
);

    localparam int unsigned P    = 2 * (GAP_CYC + PH_CYC);
    localparam int unsigned PC_W = $clog2(P);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(P - 1);
    localparam logic [PC_W-1:0] PH1_LO  = PC_W'(GAP_CYC);
    localparam logic [PC_W-1:0] PH1_HI  = PC_W'(GAP_CYC + PH_CYC);
    localparam logic [PC_W-1:0] PH2_LO  = PC_W'(2 * GAP_CYC + PH_CYC);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state, state_next;
    logic [PC_W-1:0]    pc, pc_next;
    logic [NS_W-1:0]    cnt, cnt_next, cnt_sat;
    logic [NS_W-1:0]    nsamp_q, nsamp_next;
    logic               stop_seen, stop_next, stop_hit;
    logic [LATENCY-1:0] tag, tag_next, tag_run, tag_drain;
    logic               period_end, emit;
    logic               phi1_d, phi2_d, enc_rst_d, busy_d;
    logic [2:0]         data_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            pc        <= '0;
            cnt       <= '0;
            nsamp_q   <= '0;
            stop_seen <= 1'b0;
            tag       <= '0;
            phi1_o    <= 1'b0;
            phi2_o    <= 1'b0;
            enc_rst_o <= 1'b1;
            busy_o    <= 1'b0;
            valid_o   <= 1'b0;
            data_o    <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            cnt       <= cnt_next;
            nsamp_q   <= nsamp_next;
            stop_seen <= stop_next;
            tag       <= tag_next;
            phi1_o    <= phi1_d;
            phi2_o    <= phi2_d;
            enc_rst_o <= enc_rst_d;
            busy_o    <= busy_d;
            valid_o   <= emit;
            data_o    <= data_d;
        end
    end

    // Tag shift written as a truncating cast so LATENCY=1 needs no special case.
    assign tag_run    = LATENCY'({tag, 1'b1});
    assign tag_drain  = LATENCY'({tag, 1'b0});
    assign period_end = (pc == PC_LAST);
    assign cnt_sat    = (cnt == '1) ? cnt : cnt + 1'b1;
    assign stop_hit   = stop_seen | stop_i;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        cnt_next   = cnt;
        nsamp_next = nsamp_q;
        stop_next  = stop_seen;
        tag_next   = tag;
        emit       = 1'b0;
        case (state)
            IDLE: begin
                pc_next = '0;
                if (start_i) begin
                    nsamp_next = nsamp_i;
                    cnt_next   = '0;
                    stop_next  = 1'b0;
                    tag_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                pc_next   = period_end ? '0 : pc + 1'b1;
                stop_next = stop_hit;
                if (period_end) begin
                    cnt_next  = cnt_sat;
                    stop_next = 1'b0;
                    tag_next  = tag_run;
                    emit      = tag[LATENCY-1];
                    if (((nsamp_q != '0) && (cnt_sat == nsamp_q)) || stop_hit)
                        state_next = DRAIN;
                end
            end
            DRAIN: begin
                pc_next = period_end ? '0 : pc + 1'b1;
                if (period_end) begin
                    tag_next = tag_drain;
                    emit     = tag[LATENCY-1];
                    if (tag_drain == '0)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state/pc so the registered phases line up with pc.
    always_comb begin
        enc_rst_d = (state_next == IDLE);
        busy_d    = ~enc_rst_d;
        phi1_d    = busy_d && (pc_next >= PH1_LO) && (pc_next < PH1_HI);
        phi2_d    = busy_d && (pc_next >= PH2_LO);
        data_d    = emit ? d_i : data_o;
    end

endmodule

// File: tb/tb_adc_pipe_seq_ctrl.sv
// Randomized bench for adc_pipe_seq_ctrl: LATENCY=2 and LATENCY=1 instances share stimulus
// and are checked every cycle against a cycle-index arithmetic model of a run.
module tb_adc_pipe_seq_ctrl;

    localparam int GAP = 1;
    localparam int PH  = 8;
    localparam int P   = 2 * (GAP + PH);

    logic       clk_i = 1'b0;
    logic       reset_i, start_i, stop_i;
    logic [7:0] nsamp_i;
    logic [2:0] d_i;

    logic       phi1_a, phi2_a, enc_a, busy_a, valid_a;
    logic [2:0] data_a;
    logic       phi1_b, phi2_b, enc_b, busy_b, valid_b;
    logic [2:0] data_b;

    int total = 0;
    int bad   = 0;
    logic [2:0] dper [0:63];
    logic [2:0] ed   [1:2];

    always #5 clk_i = ~clk_i;

    adc_pipe_seq_ctrl #(.PH_CYC(PH), .GAP_CYC(GAP), .LATENCY(2), .NS_W(8)) u_dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
        .nsamp_i(nsamp_i), .d_i(d_i), .phi1_o(phi1_a), .phi2_o(phi2_a),
        .enc_rst_o(enc_a), .busy_o(busy_a), .valid_o(valid_a), .data_o(data_a)
    );

    adc_pipe_seq_ctrl #(.PH_CYC(PH), .GAP_CYC(GAP), .LATENCY(1), .NS_W(8)) u_dut_l1 (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
        .nsamp_i(nsamp_i), .d_i(d_i), .phi1_o(phi1_b), .phi2_o(phi2_b),
        .enc_rst_o(enc_b), .busy_o(busy_b), .valid_o(valid_b), .data_o(data_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic chk_dut(input string pfx, input int lat, input logic ph1, input logic ph2,
                           input logic enc, input logic bsy, input logic vld);
        if (lat == 2) begin
            chk({pfx, " phi1"}, {7'd0, phi1_a}, {7'd0, ph1});
            chk({pfx, " phi2"}, {7'd0, phi2_a}, {7'd0, ph2});
            chk({pfx, " enc_rst"}, {7'd0, enc_a}, {7'd0, enc});
            chk({pfx, " busy"}, {7'd0, busy_a}, {7'd0, bsy});
            chk({pfx, " valid"}, {7'd0, valid_a}, {7'd0, vld});
            chk({pfx, " data"}, {5'd0, data_a}, {5'd0, ed[2]});
        end else begin
            chk({pfx, " phi1"}, {7'd0, phi1_b}, {7'd0, ph1});
            chk({pfx, " phi2"}, {7'd0, phi2_b}, {7'd0, ph2});
            chk({pfx, " enc_rst"}, {7'd0, enc_b}, {7'd0, enc});
            chk({pfx, " busy"}, {7'd0, busy_b}, {7'd0, bsy});
            chk({pfx, " valid"}, {7'd0, valid_b}, {7'd0, vld});
            chk({pfx, " data"}, {5'd0, data_b}, {5'd0, ed[1]});
        end
    endtask

    task automatic chk_idle(input string pfx);
        chk_dut({pfx, " L2"}, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_dut({pfx, " L1"}, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Cycle c counts from the first RUN cycle; n real samples give n+lat busy periods.
    task automatic check_cycle(input int c, input int lat, input int n);
        int per, pcv;
        logic bsy, ph1, ph2, vld;
        per = c / P;
        pcv = c % P;
        bsy = (c < (n + lat) * P);
        ph1 = bsy && (pcv >= GAP) && (pcv < GAP + PH);
        ph2 = bsy && (pcv >= 2 * GAP + PH);
        vld = (pcv == 0) && (per >= lat + 1) && (per - lat - 1 < n);
        if (vld) ed[lat] = dper[per - 1];
        chk_dut($sformatf("L%0d c%0d", lat, c), lat, ph1, ph2, ~bsy, bsy, vld);
    endtask

    task automatic run_case(input int ns, input int sp_per, input int sp_pc);
        int n_real, c_end;
        if (ns == 0)                                n_real = sp_per + 1;
        else if (sp_per >= 0 && sp_per + 1 < ns)    n_real = sp_per + 1;
        else                                        n_real = ns;
        c_end   = (n_real + 2) * P + 3;
        stop_i  = 1'b0;
        start_i = 1'b1;
        nsamp_i = 8'(ns);
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 0; c < c_end; c++) begin
            if (c % P == 0) dper[c / P] = 3'($urandom);
            check_cycle(c, 2, n_real);
            check_cycle(c, 1, n_real);
            d_i     = dper[c / P];
            start_i = (c < (n_real + 1) * P) && ($urandom_range(0, 11) == 0);
            stop_i  = (c == sp_per * P + sp_pc) ||
                      ((c >= n_real * P) && ($urandom_range(0, 7) == 0));
            nsamp_i = 8'($urandom);
            @(negedge clk_i);
        end
        start_i = 1'b0;
        stop_i  = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        start_i = 1'b0;
        stop_i  = 1'b0;
        nsamp_i = '0;
        d_i     = '0;
        ed[1]   = '0;
        ed[2]   = '0;
        repeat (2) @(negedge clk_i);
        chk_idle("reset");
        reset_i = 1'b0;
        @(negedge clk_i);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        chk_idle("stop_in_idle");

        run_case(4, -1, 0);
        run_case(0, 9, 0);
        run_case(0, 9, 17);
        run_case(1, 0, int'($urandom_range(0, P - 1)));
        run_case(3, 2, 5);
        run_case(5, 1, int'($urandom_range(0, P - 1)));
        for (int k = 0; k < 3; k++) begin
            int ns;
            ns = int'($urandom_range(1, 6));
            if ($urandom_range(0, 1) == 0) run_case(ns, -1, 0);
            else run_case(ns, int'($urandom_range(0, ns - 1)), int'($urandom_range(0, P - 1)));
        end

        start_i = 1'b1;
        nsamp_i = 8'd0;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat ($urandom_range(20, 60)) begin
            d_i = 3'($urandom);
            @(negedge clk_i);
        end
        #2 reset_i = 1'b1;
        ed[1] = '0;
        ed[2] = '0;
        #1 chk_idle("async_reset");
        @(negedge clk_i);
        reset_i = 1'b0;
        for (int c = 0; c < 2 * P; c++) begin
            d_i = 3'($urandom);
            @(negedge clk_i);
            chk_idle($sformatf("post_reset c%0d", c));
        end

        run_case(2, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
